// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks two-direction lamp sequencing and latches the first fault.
// Define TRAFFIC_MONITOR_YELLOW_MAX_EN to enable the maximum-yellow (code 5) check.
module traffic_light_monitor #(
   parameter int YELLOW_MIN = 5_000_000,
   parameter int YELLOW_MAX = 6_000_000,
   parameter int CNT_W      = 23
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  La,
   input  logic [2:0]  Lb,
   input  logic        clr_fault,
   output logic        fault,
   output logic [2:0]  fault_code,
   output logic [15:0] cycle_count
);
   typedef enum logic [1:0] {S_UNK, S_RED, S_GRN, S_YEL} state_e;
   localparam logic [CNT_W-1:0] YMIN = CNT_W'(YELLOW_MIN);
`ifdef TRAFFIC_MONITOR_YELLOW_MAX_EN
   localparam logic [CNT_W-1:0] YMAX = CNT_W'(YELLOW_MAX);
`endif
   if (YELLOW_MAX <= YELLOW_MIN) begin : g_bad_cfg
      $error("traffic_light_monitor: YELLOW_MAX must exceed YELLOW_MIN");
   end
   logic [2:0]       smp_q [2];
   logic             v_q;
   state_e           st_q [2];
   state_e           st_d [2];
   logic [CNT_W-1:0] tmr_q [2];
   logic [CNT_W-1:0] tmr_d [2];
   logic [1:0]       ill, bad_tr, short_y, long_y;
   logic             conflict;
   logic [2:0]       new_code;
   logic             fault_q, fault_d;
   logic [2:0]       code_q, code_d;
   logic [15:0]      cnt_q, cnt_d;
   function automatic state_e dec(input logic [2:0] s);
      return s == 3'b100 ? S_GRN : s == 3'b010 ? S_YEL : s == 3'b001 ? S_RED : S_UNK;
   endfunction
   // v_q marks that the sample register holds a real input rather than its reset value
   always_comb begin
      ill      = '0;
      bad_tr   = '0;
      short_y  = '0;
      long_y   = '0;
      for (int i = 0; i < 2; i++) begin
         st_d[i]    = dec(smp_q[i]);
         ill[i]     = v_q && st_d[i] == S_UNK;
         bad_tr[i]  = (st_q[i] == S_GRN && st_d[i] == S_RED) ||
                      (st_q[i] == S_YEL && st_d[i] == S_GRN) ||
                      (st_q[i] == S_RED && st_d[i] == S_YEL);
         short_y[i] = st_q[i] == S_YEL && st_d[i] == S_RED && tmr_q[i] < YMIN;
         tmr_d[i]   = st_d[i] != S_YEL ? tmr_q[i] :
                      st_q[i] != S_YEL ? '0 :
                      &tmr_q[i]        ? tmr_q[i] : tmr_q[i] + 1'b1;
`ifdef TRAFFIC_MONITOR_YELLOW_MAX_EN
         long_y[i]  = st_q[i] == S_YEL && st_d[i] == S_YEL && tmr_q[i] != YMAX && tmr_d[i] == YMAX;
`else
         long_y[i]  = 1'b0;
`endif
      end
      conflict = v_q && smp_q[0] != 3'b001 && smp_q[1] != 3'b001;
      new_code = |ill     ? 3'd1 :
                 conflict ? 3'd2 :
                 |bad_tr  ? 3'd3 :
                 |short_y ? 3'd4 :
                 |long_y  ? 3'd5 : 3'd0;
      fault_d  = clr_fault ? |new_code : fault_q | (|new_code);
      code_d   = (clr_fault || !fault_q) ? new_code : code_q;
      cnt_d    = (st_q[0] == S_YEL && st_d[0] == S_RED && !short_y[0] && cnt_q != 16'hFFFF) ?
                 cnt_q + 16'd1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q     <= 1'b0;
         fault_q <= 1'b0;
         code_q  <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < 2; i++) begin
            smp_q[i] <= '0;
            st_q[i]  <= S_UNK;
            tmr_q[i] <= '0;
         end
      end else begin
         v_q      <= 1'b1;
         smp_q[0] <= La;
         smp_q[1] <= Lb;
         fault_q  <= fault_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         for (int i = 0; i < 2; i++) begin
            st_q[i]  <= st_d[i];
            tmr_q[i] <= tmr_d[i];
         end
      end
   end
   assign fault       = fault_q;
   assign fault_code  = code_q;
   assign cycle_count = cnt_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed scenarios plus random traffic against a colour/run-length model.
module tb_traffic_light_monitor;
   localparam int MIN = 4;
   localparam int MAX = 8;
   localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001;
   localparam int CU = -1, CR = 0, CG = 1, CY = 2;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  La = R, Lb = R;
   logic        clr_fault = 1'b0;
   logic        fault;
   logic [2:0]  fault_code;
   logic [15:0] cycle_count;
   int checks = 0, errors = 0;
   int col [2];
   int yrun [2];
   logic [2:0] pend [2];
   bit  pend_v;
   bit  mf;
   int  mcode, mcnt;
   bit  started = 0;
   traffic_light_monitor #(.YELLOW_MIN(MIN), .YELLOW_MAX(MAX), .CNT_W(23)) dut (
      .clk(clk), .rst(rst), .La(La), .Lb(Lb), .clr_fault(clr_fault),
      .fault(fault), .fault_code(fault_code), .cycle_count(cycle_count));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int colof(input logic [2:0] s);
      return s == G ? CG : s == Y ? CY : s == R ? CR : CU;
   endfunction
   task automatic model_step(input logic [2:0] a, input logic [2:0] b, input bit clr, input bit r);
      int code, nx [2];
      bit ill, cfl, badt, shrt, lng;
      if (r) begin
         col = '{CU, CU}; yrun = '{0, 0}; pend = '{3'b0, 3'b0};
         pend_v = 0; mf = 0; mcode = 0; mcnt = 0;
         return;
      end
      code = 0;
      if (pend_v) begin
         ill = 0; badt = 0; shrt = 0; lng = 0;
         cfl = pend[0] != R && pend[1] != R;
         for (int d = 0; d < 2; d++) begin
            nx[d] = colof(pend[d]);
            if (nx[d] == CU) ill = 1;
            if ((col[d] == CG && nx[d] == CR) || (col[d] == CY && nx[d] == CG) ||
                (col[d] == CR && nx[d] == CY)) badt = 1;
            // yrun counts yellow samples so far; the first one is timer value 0
            if (col[d] == CY && nx[d] == CR && yrun[d] - 1 < MIN) shrt = 1;
            if (col[d] == CY && nx[d] == CR && yrun[d] - 1 >= MIN && d == 0 && mcnt < 65535) mcnt++;
            yrun[d] = nx[d] == CY ? yrun[d] + 1 : 0;
`ifdef TRAFFIC_MONITOR_YELLOW_MAX_EN
            if (col[d] == CY && nx[d] == CY && yrun[d] - 1 == MAX) lng = 1;
`endif
            col[d] = nx[d];
         end
         code = ill ? 1 : cfl ? 2 : badt ? 3 : shrt ? 4 : lng ? 5 : 0;
      end
      if (clr) begin
         mf = code != 0; mcode = code;
      end else if (!mf && code != 0) begin
         mf = 1; mcode = code;
      end
      pend[0] = a; pend[1] = b; pend_v = 1;
   endtask
   task automatic cycle(input logic [2:0] a, input logic [2:0] b, input bit clr, input bit r);
      @(negedge clk);
      La = a; Lb = b; clr_fault = clr; rst = r;
      @(posedge clk);
      if (r) started = 1;
      model_step(a, b, clr, r);
      #1;
      if (started) begin
         chk("fault", fault, mf);
         chk("fault_code", fault_code, mcode);
         chk("cycle_count", cycle_count, mcnt);
      end
   endtask
   task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
      for (int i = 0; i < n; i++) cycle(a, b, 0, 0);
   endtask
   task automatic clear_to(input logic [2:0] a, input logic [2:0] b);
      hold(a, b, 2);
      cycle(a, b, 1, 0);
      hold(a, b, 1);
   endtask
   initial begin
      logic [2:0] ra, rb;
      int fault_seen;
      cycle(R, G, 0, 1);
      cycle(R, G, 0, 1);
      chk("rst_fault", fault, 0);
      chk("rst_code", fault_code, 0);
      chk("rst_cnt", cycle_count, 0);
      fault_seen = 0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) begin cycle(G, R, 0, 0); fault_seen += fault; end
         for (int i = 0; i < 5; i++) begin cycle(Y, R, 0, 0); fault_seen += fault; end
         for (int i = 0; i < 3; i++) begin cycle(R, G, 0, 0); fault_seen += fault; end
         for (int i = 0; i < 5; i++) begin cycle(R, Y, 0, 0); fault_seen += fault; end
      end
      for (int i = 0; i < 2; i++) begin cycle(G, R, 0, 0); fault_seen += fault; end
      chk("s1_no_fault", fault_seen, 0);
      chk("s1_cnt", cycle_count, 2);
      cycle(G, G, 0, 0);
      hold(G, R, 2);
      chk("s2_fault", fault, 1);
      chk("s2_code", fault_code, 2);
      clear_to(G, R);
      chk("s3_cleared", fault, 0);
      cycle(R, G, 0, 0);
      hold(R, G, 2);
      chk("s3_code3", fault_code, 3);
      cycle(R, G, 1, 0);
      chk("s3_clr", fault, 0);
      cycle(3'b110, G, 0, 0);
      hold(R, G, 2);
      chk("s3_code1", fault_code, 1);
      clear_to(R, G);
      hold(R, Y, 5);
      hold(G, R, 3);
      hold(Y, R, 2);
      hold(R, R, 2);
      chk("s4_code4", fault_code, 4);
      cycle(R, 3'b000, 1, 0);
      hold(R, R, 2);
      chk("s4_code1", fault_code, 1);
      cycle(G, G, 0, 0);
      cycle(R, G, 1, 0);
      chk("clr_vs_violation", fault_code, 2);
      clear_to(R, G);
      hold(R, Y, 5);
      hold(G, R, 2);
      hold(Y, R, 10);
      hold(R, R, 2);
`ifdef TRAFFIC_MONITOR_YELLOW_MAX_EN
      chk("s5_code5", fault_code, 5);
`else
      chk("s5_no_fault", fault, 0);
`endif
      hold(R, G, 2);
      hold(R, Y, 5);
      hold(G, R, 2);
      hold(Y, G, 1);
      hold(Y, R, 2);
      chk("s6_pre_fault", fault, 1);
      cycle(Y, R, 0, 1);
      cycle(Y, R, 0, 1);
      hold(R, G, 3);
      chk("s6_fault", fault, 0);
      chk("s6_cnt", cycle_count, 0);
      ra = R; rb = G;
      for (int n = 0; n < 3000; n++) begin
         int p;
         p = $urandom_range(0, 99);
         if (p >= 80 && p < 90) begin
            ra = $urandom_range(0, 9) == 0 ? 3'($urandom) : (3'b001 << $urandom_range(0, 2));
            rb = $urandom_range(0, 9) == 0 ? 3'($urandom) : (3'b001 << $urandom_range(0, 2));
         end else if (p >= 90) begin
            ra = (ra == G) ? Y : (ra == Y) ? R : G;
            rb = (ra == R) ? ((rb == R) ? G : rb) : R;
         end
         cycle(ra, rb, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
